// File: rtl/pipemem_pkg.sv
// Shared encodings and lane helpers for the pipelined CPU memory stage.
package pipemem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Right-aligned store data copied onto every lane; byte enables pick the live ones.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/pipemem_mmio_if.sv
// MEM-stage request/response bundle between the EXE/MEM register and the memory stage.
interface pipemem_mmio_if;
  // mstall is the only flow control: while it is high the requester holds every
  // request field stable; a load result on mmo is valid in the cycle mstall is low.
  logic        mrd;
  logic        mwmem;
  logic [1:0]  msize;
  logic        munsigned;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;
  logic        mstall;
  logic        misalign;

  modport master (
    output mrd, mwmem, msize, munsigned, malu, mb,
    input  mmo, mstall, misalign
  );

  modport slave (
    input  mrd, mwmem, msize, munsigned, malu, mb,
    output mmo, mstall, misalign
  );
endinterface

// File: rtl/mmio_dmem.sv
// Data RAM: synchronous read, per-byte write enables, no reset on contents.
module mmio_dmem #(
  parameter int WORDS = 32,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipemem_mmio.sv
// Memory stage: data RAM with a one-cycle load stall, memory-mapped I/O ports,
// sub-word accesses with sign/zero extension.
module pipemem_mmio
  import pipemem_pkg::*;
#(
  parameter int DMEM_WORDS = 32,
  parameter int N_IN       = 3,
  parameter int N_OUT      = 3,
  parameter int IO_BIT     = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  pipemem_mmio_if.slave        bus,
  input  logic [32*N_IN-1:0]   in_port,
  output logic [32*N_OUT-1:0]  out_port,
  output state_t               state_dbg
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int PW = IO_BIT - 2;

  logic [1:0]        lane;
  logic              is_io, mis, aligned, store, load, ram_load, ram_we, io_we, ram_re;
  logic [PW-1:0]     io_idx;
  logic [AW-1:0]     ram_idx;
  logic [3:0]        be;
  logic [31:0]       wdata, ram_rdata, io_rdata, mmo, unused_hi;
  logic              mstall;
  logic [32*N_IN-1:0] sync1, sync2;
  state_t            state, state_nxt;

  assign lane    = bus.malu[1:0];
  assign is_io   = bus.malu[IO_BIT];
  assign io_idx  = bus.malu[IO_BIT-1:2];
  assign ram_idx = bus.malu[AW+1:2];
  assign mis     = is_misaligned(bus.msize, lane);
  assign aligned = ~mis;
  assign be      = byte_en(bus.msize, lane);
  assign wdata   = store_data(bus.msize, bus.mb);

  // A simultaneous mrd/mwmem is a store; the load path never sees it.
  assign store    = bus.mwmem;
  assign load     = bus.mrd & ~bus.mwmem;
  assign ram_load = load & aligned & ~is_io;
  assign ram_we   = store & aligned & ~is_io & (state == ST_IDLE);
  assign io_we    = store & aligned & is_io & (state == ST_IDLE);

  assign unused_hi = 32'(bus.malu >> (IO_BIT + 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mstall    = 1'b0;
    mmo       = '0;
    ram_re    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ram_load) begin
          state_nxt = ST_RD;
          mstall    = 1'b1;
          ram_re    = 1'b1;
        end else if (load & aligned & is_io) begin
          mmo = load_ext(io_rdata, bus.msize, lane, bus.munsigned);
        end
      end
      ST_RD: begin
        state_nxt = ST_IDLE;
        mmo       = load_ext(ram_rdata, bus.msize, lane, bus.munsigned);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.mmo      = mmo;
  assign bus.mstall   = mstall;
  assign bus.misalign = mis;
  assign state_dbg    = state;

  mmio_dmem #(.WORDS(DMEM_WORDS)) u_dmem (
    .clock (clock),
    .we    (ram_we),
    .be    (be),
    .waddr (ram_idx),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (ram_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Unpopulated port indices read as zero.
  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (io_idx == PW'(k)) io_rdata = sync2[32*k +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_port <= '0;
    end else if (io_we) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (io_idx == PW'(k)) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) out_port[32*k + 8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipemem_mmio.sv
// Directed bench for pipemem_mmio: drivers push expected load results, a monitor checks mmo.
module tb_pipemem_mmio;
  import pipemem_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_OUT = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [32*N_IN-1:0]  in_port = '0;
  logic [32*N_OUT-1:0] out_port;
  state_t              state_dbg;

  pipemem_mmio_if bus ();

  pipemem_mmio #(
    .DMEM_WORDS (32),
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .IO_BIT     (7)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .in_port   (in_port),
    .out_port  (out_port),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a load result is presented whenever a load is up and mstall is low.
  always @(negedge clock) begin
    string nm;
    if (!reset && bus.mrd && !bus.mwmem && !bus.mstall) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%08h expected none", bus.mmo);
      end else begin
        nm = name_q.pop_front();
        check(nm, bus.mmo, exp_q.pop_front());
      end
    end
  end

  // Drivers are entered and left just after a rising edge.
  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                          input logic rd, input logic exp_mis, input string nm);
    bus.mwmem = 1'b1;
    bus.mrd = rd;
    bus.malu = addr;
    bus.msize = size;
    bus.mb = data;
    bus.munsigned = 1'b0;
    @(negedge clock);
    check({nm, "_mis"}, 32'(bus.misalign), 32'(exp_mis));
    check({nm, "_stall"}, 32'(bus.mstall), 32'd0);
    @(posedge clock);
    #1;
    bus.mwmem = 1'b0;
    bus.mrd = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp, input int exp_stall, input logic exp_mis,
                         input string nm);
    int stalls;
    bus.mrd = 1'b1;
    bus.mwmem = 1'b0;
    bus.malu = addr;
    bus.msize = size;
    bus.munsigned = uns;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    stalls = 0;
    @(negedge clock);
    check({nm, "_mis"}, 32'(bus.misalign), 32'(exp_mis));
    if (bus.mstall) check({nm, "_idle_mmo"}, bus.mmo, 32'd0);
    while (bus.mstall && stalls < 8) begin
      stalls++;
      @(negedge clock);
    end
    if (bus.mstall) begin
      check({nm, "_timeout"}, 32'(bus.mstall), 32'd0);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    check({nm, "_lat"}, 32'(stalls), 32'(exp_stall));
    @(posedge clock);
    #1;
    bus.mrd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mrd = 1'b0;
    bus.mwmem = 1'b0;
    bus.msize = SZ_WORD;
    bus.munsigned = 1'b0;
    bus.malu = '0;
    bus.mb = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_port", out_port[31:0] | out_port[63:32] | out_port[95:64], 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_mstall", 32'(bus.mstall), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Output port stores
    do_store(32'h80, SZ_WORD, 32'hDEADBEEF, 1'b0, 1'b0, "sw_io0");
    check("out0_word", out_port[31:0], 32'hDEADBEEF);
    do_store(32'h81, SZ_BYTE, 32'h12, 1'b0, 1'b0, "sb_io0");
    check("out0_byte", out_port[31:0], 32'hDEAD12EF);

    // RAM sub-word loads
    do_store(32'h04, SZ_WORD, 32'h80F07F01, 1'b0, 1'b0, "sw_ram4");
    do_load(32'h07, SZ_BYTE, 1'b0, 32'hFFFFFF80, 1, 1'b0, "lb_07");
    do_load(32'h07, SZ_BYTE, 1'b1, 32'h00000080, 1, 1'b0, "lbu_07");
    do_load(32'h04, SZ_HALF, 1'b0, 32'h00007F01, 1, 1'b0, "lh_04");
    do_load(32'h06, SZ_HALF, 1'b0, 32'hFFFF80F0, 1, 1'b0, "lh_06");
    do_load(32'h06, SZ_HALF, 1'b1, 32'h000080F0, 1, 1'b0, "lhu_06");
    do_load(32'h05, SZ_BYTE, 1'b0, 32'h0000007F, 1, 1'b0, "lb_05");
    do_load(32'h04, SZ_WORD, 1'b0, 32'h80F07F01, 1, 1'b0, "lw_04");

    // Input port through the two-flop synchroniser
    in_port[63:32] = 32'h55AA0000;
    do_load(32'h84, SZ_WORD, 1'b0, 32'h00000000, 0, 1'b0, "lw_in1_e0");
    do_load(32'h84, SZ_WORD, 1'b0, 32'h00000000, 0, 1'b0, "lw_in1_e1");
    do_load(32'h84, SZ_WORD, 1'b0, 32'h55AA0000, 0, 1'b0, "lw_in1_e2");
    do_load(32'h86, SZ_HALF, 1'b0, 32'h000055AA, 0, 1'b0, "lh_in1_hi");
    do_load(32'h8C, SZ_WORD, 1'b0, 32'h00000000, 0, 1'b0, "lw_in_oob");

    // Misaligned accesses
    do_load(32'h02, SZ_WORD, 1'b0, 32'h00000000, 0, 1'b1, "lw_mis02");
    do_store(32'h00, SZ_WORD, 32'h11223344, 1'b0, 1'b0, "sw_ram0");
    do_store(32'h01, SZ_HALF, 32'h0000FFFF, 1'b0, 1'b1, "sh_mis01");
    do_load(32'h00, SZ_WORD, 1'b0, 32'h11223344, 1, 1'b0, "lw_after_mis");

    // Store immediately followed by load of the same word
    do_store(32'h08, SZ_WORD, 32'hA5A55A5A, 1'b0, 1'b0, "sw_ram8");
    do_load(32'h08, SZ_WORD, 1'b0, 32'hA5A55A5A, 1, 1'b0, "lw_raw8");
    do_store(32'h0A, SZ_HALF, 32'h0000BEEF, 1'b0, 1'b0, "sh_ram0a");
    do_load(32'h08, SZ_WORD, 1'b0, 32'hBEEF5A5A, 1, 1'b0, "lw_half8");

    // Reset during the RD cycle drops the load
    bus.mrd = 1'b1;
    bus.mwmem = 1'b0;
    bus.malu = 32'h04;
    bus.msize = SZ_WORD;
    bus.munsigned = 1'b0;
    @(negedge clock);
    check("rdrst_stall_before", 32'(bus.mstall), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.mrd = 1'b0;
    #1;
    check("rdrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rdrst_stall", 32'(bus.mstall), 32'd0);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rdrst_out0", out_port[31:0], 32'd0);
    do_load(32'h04, SZ_WORD, 1'b0, 32'h80F07F01, 1, 1'b0, "lw_after_rst");

    // mrd with mwmem acts as a store
    do_store(32'h88, SZ_WORD, 32'h3, 1'b1, 1'b0, "rdwr_io2");
    check("out2_rdwr", out_port[95:64], 32'h3);

    repeat (2) @(posedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipemem_mmio.md
# pipemem_mmio

Parametrised memory stage for the pipelined CPU. It replaces the fixed 32-word data memory and 3-port I/O with a configurable data RAM, configurable input and output port counts, and byte/halfword/word accesses with sign or zero extension. Data RAM reads are synchronous, so a data-memory load stalls the pipeline for one cycle through a handshake. The block sits between the EXE/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- DMEM_WORDS, 32: data RAM depth in 32-bit words; power of 2, ≤ 2^(IO_BIT-2).
- N_IN, 3: number of 32-bit input ports, 1..2^(IO_BIT-2).
- N_OUT, 3: number of 32-bit output ports, 1..2^(IO_BIT-2).
- IO_BIT, 7: address bit that selects the I/O region (1) or the data RAM (0).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mrd  in  1  load request.
- mwmem  in  1  store request.
- msize  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- munsigned  in  1  zero-extend sub-word loads (1) or sign-extend them (0).
- malu  in  32  byte address.
- mb  in  32  store data, right-aligned.
- in_port  in  32*N_IN  packed input ports; port k is bits [32k+31:32k].
- out_port  out  32*N_OUT  packed output registers.
- mmo  out  32  load result, extended.
- mstall  out  1  hold the pipeline; MEM inputs must stay stable while it is high.
- misalign  out  1  misaligned access flag; combinational.

## Operation
Address decode:
- malu[IO_BIT]=0: data RAM; word index is malu[log2(DMEM_WORDS)+1:2].
- malu[IO_BIT]=1: I/O; port index is malu[IO_BIT-1:2].
- Lane is malu[1:0].

Misalignment:
- misalign=1 when a half access has malu[0]=1, or a word access has malu[1:0]≠00.
- A misaligned access writes nothing, does not stall, and drives mmo=0.

Stores:
- Single cycle, applied at the edge while the FSM is in IDLE.
- Byte enables come from msize and the lane; data is replicated onto the selected lanes.
- I/O stores to port index ≥ N_OUT are ignored.
- If mrd and mwmem are both asserted, the access is a store.

I/O loads:
- Single cycle, no stall.
- Read data comes from the synchronised input registers.
- Port index ≥ N_IN reads 0.

Data RAM loads use a two-state FSM:
- IDLE: an aligned mrd to the RAM issues a synchronous read and drives mstall=1 combinationally; next state is RD. Any other access stays in IDLE with mstall=0.
- RD: mstall=0 and mmo = the extracted lane, extended; next state is IDLE unconditionally.

Extraction:
- The byte or half is taken at the lane offset.
- It is sign-extended unless munsigned=1.

Input synchroniser:
- Two flops per input port, reset to 0.

mmo when idle:
- mmo=0 when there is no load, or in the IDLE cycle of a data RAM load.

Reset values:
- out_port all 0, synchroniser flops 0, FSM in IDLE, mstall 0.
- Data RAM contents are not reset.
- A reset asserted while in RD returns the FSM to IDLE immediately; the pending load is dropped.

## Timing
- Store in cycle n: out_port or RAM is updated at the end of cycle n; out_port is visible in cycle n+1.
- Data RAM load requested in cycle n: mstall=1 in n; mmo valid in n+1 with mstall=0.
- A store at n followed by a load to the same word at n+1 returns the new data at n+2.
- An in_port change sampled at edge e is visible to I/O loads two edges later.
- Back-to-back data RAM loads: each costs 2 cycles; the FSM returns to IDLE between them.

## Structure
- Package pipemem_pkg holds:
  - the msize encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the byte-enable generation function;
  - the load-extension function;
  - the FSM state enum (ST_IDLE, ST_RD).
- Sub-module mmio_dmem: a DMEM_WORDS × 32 synchronous-read RAM with 4 byte-write enables. Top-level write enable = store & aligned & ~malu[IO_BIT] & state==IDLE.

## Test plan
- Reset, then read out_port → all 0. Word store 0xDEADBEEF to 0x80 → out_port0=0xDEADBEEF next cycle. Byte store 0x12 to 0x81 → out_port0=0xDEAD12EF.
- Word store 0x80F0_7F01 to RAM 0x04. Then:
  - lb at 0x07 → mstall for 1 cycle, then mmo=0xFFFFFF80;
  - lbu at 0x07 → 0x00000080;
  - lh at 0x04 → 0x00007F01.
- in_port1=0x55AA0000, lw at 0x84 → returns 0x55AA0000 no earlier than 2 edges after the change. Load from port index N_IN → 0.
- Misalignment: lw at 0x02 → misalign=1, mstall=0, mmo=0. sh at 0x01 → RAM is unchanged, checked by a later aligned read.
- Assert reset during the RD cycle of a load → mstall=0, FSM in IDLE. The next load completes normally in 2 cycles.
- mrd and mwmem together to 0x88 with data 0x3 → out_port2=3 and no stall.
